instr_exec_unit: RTL



---
 rtl/instr_register_pkg.sv | 37 +++
 rtl/instr_exec_unit_if.sv | 27 ++
 rtl/iter_divider.sv | 83 ++++++++
 rtl/instr_exec_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execute stage.
package instr_register_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OPND_W = 32;
  localparam int unsigned RES_W  = 2 * OPND_W;

  typedef logic signed [OPND_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;
  typedef logic        [ADDR_W-1:0] address_t;

  // Encodings 8..15 are reserved and reported as illegal.
  typedef enum logic [OPC_W-1:0] {
    OPC_ZERO  = 4'd0,
    OPC_PASSA = 4'd1,
    OPC_PASSB = 4'd2,
    OPC_ADD   = 4'd3,
    OPC_SUB   = 4'd4,
    OPC_MULT  = 4'd5,
    OPC_DIV   = 4'd6,
    OPC_MOD   = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} exec_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic is_div_op(opcode_t opc);
    return (opc == OPC_DIV) || (opc == OPC_MOD);
  endfunction

  function automatic logic is_legal_op(opcode_t opc);
    return !opc[OPC_W-1];
  endfunction

endpackage

// File: rtl/instr_exec_unit_if.sv
// Instruction-in / result-out handshake bundle of the execute stage.
interface instr_exec_unit_if;
  import instr_register_pkg::*;

  logic     in_valid;
  logic     in_ready;
  opcode_t  in_opc;
  operand_t in_op_a;
  operand_t in_op_b;
  address_t in_addr;
  logic     out_valid;
  logic     out_ready;
  result_t  out_result;
  address_t out_addr;
  logic     out_div0;
  logic     out_illegal;

  modport master (
    output in_valid, in_opc, in_op_a, in_op_b, in_addr, out_ready,
    input  in_ready, out_valid, out_result, out_addr, out_div0, out_illegal
  );

  modport slave (
    input  in_valid, in_opc, in_op_a, in_op_b, in_addr, out_ready,
    output in_ready, out_valid, out_result, out_addr, out_div0, out_illegal
  );
endinterface

// File: rtl/iter_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses for one
// cycle once quotient/remainder are final.
module iter_divider
  import instr_register_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W:0]       shifted;
  logic [W:0]       diff;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[W-1]};
    // diff[W] is the borrow: set when the trial subtraction must be undone
    diff    = shifted - {1'b0, dvs_q};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (busy_q) begin
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: one instruction per handshake, single-cycle ALU ops plus an
// iterative signed DIV/MOD; result and address tag are held until consumed.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int unsigned OPERAND_W = 32,
  parameter int unsigned RESULT_W  = 2 * OPERAND_W
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_exec_unit_if.slave   bus
);

  exec_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  result_t     result_q, result_d;
  address_t    addr_q, addr_d;
  logic        div0_q, div0_d;
  logic        illegal_q, illegal_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        mod_q, mod_d;

  logic                 accept;
  logic                 div_start;
  logic                 div_done;
  logic [OPERAND_W-1:0] mag_a, mag_b;
  logic [OPERAND_W-1:0] div_quo, div_rem;
  logic [RESULT_W-1:0]  mag_res;
  result_t              a_ext, b_ext, alu_res;

  assign accept = bus.in_valid && in_ready_q;
  assign a_ext  = RESULT_W'(bus.in_op_a);
  assign b_ext  = RESULT_W'(bus.in_op_b);
  assign mag_a  = bus.in_op_a[OPERAND_W-1] ? OPERAND_W'(-bus.in_op_a) : OPERAND_W'(bus.in_op_a);
  assign mag_b  = bus.in_op_b[OPERAND_W-1] ? OPERAND_W'(-bus.in_op_b) : OPERAND_W'(bus.in_op_b);

  // Single-cycle datapath; operands widened first so ADD/SUB/MULT never overflow
  always_comb begin
    alu_res = '0;
    case (bus.in_opc)
      OPC_PASSA: alu_res = a_ext;
      OPC_PASSB: alu_res = b_ext;
      OPC_ADD:   alu_res = a_ext + b_ext;
      OPC_SUB:   alu_res = a_ext - b_ext;
      OPC_MULT:  alu_res = a_ext * b_ext;
      default:   alu_res = '0;
    endcase
  end

  iter_divider #(.W(OPERAND_W)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign mag_res = mod_q ? RESULT_W'(div_rem) : RESULT_W'(div_quo);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    addr_d    = addr_q;
    div0_d    = div0_q;
    illegal_d = illegal_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    mod_d     = mod_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = DONE;
          addr_d    = bus.in_addr;
          result_d  = '0;
          div0_d    = 1'b0;
          illegal_d = 1'b0;
          if (!is_legal_op(bus.in_opc)) begin
            illegal_d = 1'b1;
          end else if (is_div_op(bus.in_opc)) begin
            if (bus.in_op_b == '0) begin
              div0_d = 1'b1;
            end else begin
              div_start = 1'b1;
              state_d   = DIV_RUN;
              neg_quo_d = bus.in_op_a[OPERAND_W-1] ^ bus.in_op_b[OPERAND_W-1];
              neg_rem_d = bus.in_op_a[OPERAND_W-1];
              mod_d     = (bus.in_opc == OPC_MOD);
            end
          end else begin
            result_d = alu_res;
          end
        end
      end
      DIV_RUN: begin
        // Quotient sign is the XOR of operand signs; remainder follows the dividend
        if (div_done) begin
          result_d = ((mod_q ? neg_rem_q : neg_quo_q)) ? RESULT_W'(-mag_res) : RESULT_W'(mag_res);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      addr_q      <= '0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      mod_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      mod_q       <= mod_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = result_q;
  assign bus.out_addr    = addr_q;
  assign bus.out_div0    = div0_q;
  assign bus.out_illegal = illegal_q;

endmodule
